// File: rtl/multicycle_adder.sv
// Chunk-serial adder/subtractor: one CHUNK-bit add per RUN cycle, with the result held in DONE until it is consumed.
// State table:  IDLE | waiting for operands (in_ready=1)
//               RUN  | adding chunk r_k, low chunk first
//               DONE | result valid, held until out_ready
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK:0]   w_chunk;
    logic             w_last;
    logic             w_msb_cin;

    // r_b already holds the effective operand, so subtract is just an add here
    assign w_chunk = {1'b0, r_a[int'(r_k)*CHUNK +: CHUNK]}
                   + {1'b0, r_b[int'(r_k)*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, r_carry};
    assign w_last    = (r_k == K_LAST);
    // carry into the MSB recovered from the MSB's own sum bit
    assign w_msb_cin = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_chunk[CHUNK-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_k     <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[int'(r_k)*CHUNK +: CHUNK] <= w_chunk[CHUNK-1:0];
                    r_carry <= w_chunk[CHUNK];
                    r_k     <= r_k + KW'(1);
                    if (w_last) begin
                        r_cout <= w_chunk[CHUNK];
                        r_ovf  <= w_msb_cin ^ w_chunk[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder at WIDTH=16, CHUNK=4.
module tb_multicycle_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    logic [17:0] sb_q[$];

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // returns {ovf, cout, sum}
    function automatic logic [17:0] model(input logic [15:0] ia, input logic [15:0] ib,
                                          input logic icin, input logic isub);
        logic [15:0] bp;
        logic [16:0] full;
        logic        v;
        bp   = isub ? ~ib : ib;
        full = {1'b0, ia} + {1'b0, bp} + {16'd0, (isub ? 1'b1 : icin)};
        v    = (ia[15] == bp[15]) && (full[15] != ia[15]);
        return {v, full[16], full[15:0]};
    endfunction

    task automatic sb_compare(input string tag);
        logic [17:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_sum"},  32'(sum),  32'(e[15:0]));
            chk({tag, "_cout"}, 32'(cout), 32'(e[16]));
            chk({tag, "_ovf"},  32'(ovf),  32'(e[17]));
        end
    endtask

    // Called #1 after an edge with the DUT in IDLE; returns #1 after the edge entering DONE.
    task automatic do_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic icin, input logic isub);
        int lat;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
        sb_q.push_back(model(ia, ib, icin, isub));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        sb_compare(tag);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] hs;
        logic        hc, hv;
        int          seen;
        int          last_acc;
        int          n_acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0); consume("wrap");
        do_op("povf",   16'h7FFF, 16'h0001, 1'b0, 1'b0); consume("povf");
        do_op("cin",    16'h1234, 16'h1111, 1'b1, 1'b0); consume("cin");
        do_op("sub_n",  16'h0005, 16'h0007, 1'b1, 1'b1); consume("sub_n");
        do_op("sub_ov", 16'h8000, 16'h0001, 1'b0, 1'b1); consume("sub_ov");
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // backpressure: result must hold while new operands are offered
        do_op("bp", 16'h4321, 16'h0FED, 1'b1, 1'b0);
        hs = 16'h4321 + 16'h0FED + 16'd1; hc = 1'b0; hv = 1'b0;
        in_valid = 1'b1; a = 16'h9999; b = 16'h7777; cin = 1'b0; sub = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_sum", 32'(sum), 32'(hs));
            chk("bp_cout", 32'(cout), 32'(hc));
            chk("bp_ovf", 32'(ovf), 32'(hv));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        consume("bp");
        @(posedge clk); #1;
        chk("bp_no_stale_accept", 32'(in_ready), 32'd1);

        // reset two cycles after accept aborts the operation
        a = 16'h00F0; b = 16'h0F0F; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_sum", 32'(sum), 32'd0);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("abort_no_result", 32'(seen), 32'd0);
        do_op("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0);
        chk("post_rst_sum3", 32'(sum), 32'h3);
        consume("post_rst");

        // back-to-back with operands changing every cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        last_acc = -1;
        n_acc = 0;
        for (int cyc = 0; cyc < 62; cyc++) begin
            if (out_valid) sb_compare("b2b");
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            if (in_ready) begin
                sb_q.push_back(model(a, b, cin, sub));
                if (last_acc >= 0) chk("b2b_interval", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                n_acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) begin
            if (out_valid) sb_compare("b2b_tail");
            @(posedge clk); #1;
        end
        chk("b2b_accepts", 32'(n_acc), 32'd11);
        chk("b2b_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
